// File: rtl/nfc_cmd_addr_gen_if.sv
// SFR/engine bus for the NFC command/address phase engine.
// The SFR block drives the command fields; the engine returns pad and status signals.
interface nfc_cmd_addr_gen_if;
    logic [7:0]  nf_cmd;
    logic        nf_cmd_valid;
    logic        nf_addr_en;
    logic [2:0]  nf_column_addr_cnt;
    logic [2:0]  nf_row_addr_cnt;
    logic [31:0] nf_column_addr;
    logic [31:0] nf_row_addr;
    logic [2:0]  nf_total_cycle;
    logic [3:0]  nf_high_cycle;

    logic        nf_cle_o;
    logic        nf_ale_o;
    logic        nf_web_o;
    logic [7:0]  nf_dq_o;
    logic        nf_dq_oe;
    logic        addr_clear;
    logic        cmd_done;
    logic        cmd_busy;
    logic        cmd_err;

    modport master (
        output nf_cmd,
        output nf_cmd_valid,
        output nf_addr_en,
        output nf_column_addr_cnt,
        output nf_row_addr_cnt,
        output nf_column_addr,
        output nf_row_addr,
        output nf_total_cycle,
        output nf_high_cycle,
        input  nf_cle_o,
        input  nf_ale_o,
        input  nf_web_o,
        input  nf_dq_o,
        input  nf_dq_oe,
        input  addr_clear,
        input  cmd_done,
        input  cmd_busy,
        input  cmd_err
    );

    modport slave (
        input  nf_cmd,
        input  nf_cmd_valid,
        input  nf_addr_en,
        input  nf_column_addr_cnt,
        input  nf_row_addr_cnt,
        input  nf_column_addr,
        input  nf_row_addr,
        input  nf_total_cycle,
        input  nf_high_cycle,
        output nf_cle_o,
        output nf_ale_o,
        output nf_web_o,
        output nf_dq_o,
        output nf_dq_oe,
        output addr_clear,
        output cmd_done,
        output cmd_busy,
        output cmd_err
    );
endinterface

// File: rtl/nfc_cmd_addr_gen.sv
// NAND command/address phase engine: sends one CLE byte, then optional ALE column/row bytes,
// each in a fixed-length WE# slot, followed by an idle guard window.
module nfc_cmd_addr_gen #(
    parameter int unsigned ADDR_BYTE_MAX = 4,
    parameter int unsigned GUARD_CYCLES  = 1
) (
    input logic               nfc_clk,
    input logic               rstb_nfc,
    nfc_cmd_addr_gen_if.slave bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCmd   = 3'd1;
    localparam logic [2:0] StCol   = 3'd2;
    localparam logic [2:0] StRow   = 3'd3;
    localparam logic [2:0] StGuard = 3'd4;

    localparam logic [2:0] AddrMax   = 3'(ADDR_BYTE_MAX);
    localparam logic [3:0] GuardLast = 4'(GUARD_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;

    // Shadow copies of the SFR fields, frozen for the whole sequence.
    logic [7:0]  cmd_q;
    logic        addr_en_q;
    logic [2:0]  col_cnt_q;
    logic [2:0]  row_cnt_q;
    logic [31:0] col_q;
    logic [31:0] row_q;
    logic [3:0]  period_q;
    logic [3:0]  low_q;

    logic       cle_q, cle_d;
    logic       ale_q, ale_d;
    logic       web_q, web_d;
    logic [7:0] dq_q, dq_d;
    logic       oe_q, oe_d;
    logic       clr_q, clr_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic       idle;
    logic       accept;
    logic       slot_end;
    logic [2:0] col_cnt_c;
    logic [2:0] row_cnt_c;
    logic [3:0] period_c;
    logic [3:0] high_c;
    logic [3:0] low_c;
    logic [7:0] col_byte;
    logic [7:0] row_byte;
    logic [2:0] after_cmd;
    logic [2:0] after_col;

    // The engine counts as idle only once the registered outputs have dropped busy too.
    assign idle     = (state_q == StIdle) && !busy_q;
    assign accept   = bus.nf_cmd_valid && idle;
    assign slot_end = (cnt_q == period_q - 4'd1);

    always_comb begin
        col_cnt_c = (bus.nf_column_addr_cnt > AddrMax) ? AddrMax : bus.nf_column_addr_cnt;
        row_cnt_c = (bus.nf_row_addr_cnt > AddrMax) ? AddrMax : bus.nf_row_addr_cnt;
        period_c  = {1'b0, bus.nf_total_cycle} + 4'd2;
        if (bus.nf_high_cycle == 4'd0) begin
            high_c = 4'd1;
        end else if (bus.nf_high_cycle > period_c - 4'd1) begin
            high_c = period_c - 4'd1;
        end else begin
            high_c = bus.nf_high_cycle;
        end
        low_c = period_c - high_c;
    end

    always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
        if (!rstb_nfc) begin
            cmd_q     <= 8'h00;
            addr_en_q <= 1'b0;
            col_cnt_q <= 3'd0;
            row_cnt_q <= 3'd0;
            col_q     <= 32'h0;
            row_q     <= 32'h0;
            period_q  <= 4'd2;
            low_q     <= 4'd1;
        end else if (accept) begin
            cmd_q     <= bus.nf_cmd;
            addr_en_q <= bus.nf_addr_en;
            col_cnt_q <= col_cnt_c;
            row_cnt_q <= row_cnt_c;
            col_q     <= bus.nf_column_addr;
            row_q     <= bus.nf_row_addr;
            period_q  <= period_c;
            low_q     <= low_c;
        end
    end

    always_comb begin
        col_byte = 8'h00;
        row_byte = 8'h00;
        for (int b = 0; b < 4; b++) begin
            if (idx_q == 3'(b)) begin
                col_byte = col_q[8*b +: 8];
                row_byte = row_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        if (!addr_en_q) begin
            after_cmd = StGuard;
        end else if (col_cnt_q != 3'd0) begin
            after_cmd = StCol;
        end else if (row_cnt_q != 3'd0) begin
            after_cmd = StRow;
        end else begin
            after_cmd = StGuard;
        end
        after_col = (row_cnt_q != 3'd0) ? StRow : StGuard;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCmd;
                    cnt_d   = 4'd0;
                    idx_d   = 3'd0;
                end
            end
            StCmd: begin
                if (slot_end) begin
                    state_d = after_cmd;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCol: begin
                if (slot_end) begin
                    cnt_d = 4'd0;
                    if (idx_q == col_cnt_q - 3'd1) begin
                        state_d = after_col;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRow: begin
                if (slot_end) begin
                    cnt_d = 4'd0;
                    if (idx_q == row_cnt_q - 3'd1) begin
                        state_d = StGuard;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StGuard: begin
                if (cnt_q == GuardLast) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Outputs are the registered decode of the current state, so pins lag state by one clock.
    always_comb begin
        cle_d  = 1'b0;
        ale_d  = 1'b0;
        web_d  = 1'b1;
        dq_d   = 8'h00;
        oe_d   = 1'b0;
        clr_d  = 1'b0;
        done_d = 1'b0;
        busy_d = 1'b0;
        err_d  = bus.nf_cmd_valid && !idle;
        case (state_q)
            StCmd: begin
                cle_d  = 1'b1;
                dq_d   = cmd_q;
                oe_d   = 1'b1;
                web_d  = (cnt_q >= low_q);
                busy_d = 1'b1;
            end
            StCol: begin
                ale_d  = 1'b1;
                dq_d   = col_byte;
                oe_d   = 1'b1;
                web_d  = (cnt_q >= low_q);
                busy_d = 1'b1;
            end
            StRow: begin
                ale_d  = 1'b1;
                dq_d   = row_byte;
                oe_d   = 1'b1;
                web_d  = (cnt_q >= low_q);
                busy_d = 1'b1;
            end
            StGuard: begin
                busy_d = 1'b1;
                done_d = (cnt_q == 4'd0);
                clr_d  = (cnt_q == 4'd0) && addr_en_q;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
        if (!rstb_nfc) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= 3'd0;
            cle_q   <= 1'b0;
            ale_q   <= 1'b0;
            web_q   <= 1'b1;
            dq_q    <= 8'h00;
            oe_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cle_q   <= cle_d;
            ale_q   <= ale_d;
            web_q   <= web_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.nf_cle_o   = cle_q;
    assign bus.nf_ale_o   = ale_q;
    assign bus.nf_web_o   = web_q;
    assign bus.nf_dq_o    = dq_q;
    assign bus.nf_dq_oe   = oe_q;
    assign bus.addr_clear = clr_q;
    assign bus.cmd_done   = done_q;
    assign bus.cmd_busy   = busy_q;
    assign bus.cmd_err    = err_q;

endmodule

// File: tb/tb_nfc_cmd_addr_gen.sv
// Bench for nfc_cmd_addr_gen: a per-clock reference trace is queued when a command starts
// and popped/compared against the pins one clock at a time.
module tb_nfc_cmd_addr_gen;
    localparam int GC  = 1;
    localparam int ABM = 4;

    typedef struct packed {
        logic       cle;
        logic       ale;
        logic       web;
        logic [7:0] dq;
        logic       oe;
        logic       clr;
        logic       done;
        logic       busy;
        logic       err;
    } rec_t;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    nfc_cmd_addr_gen_if bus ();

    nfc_cmd_addr_gen #(
        .ADDR_BYTE_MAX(ABM),
        .GUARD_CYCLES (GC)
    ) dut (
        .nfc_clk (clk),
        .rstb_nfc(rstb),
        .bus     (bus)
    );

    rec_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic rec_t idle_rec();
        rec_t r;
        r     = '0;
        r.web = 1'b1;
        return r;
    endfunction

    function automatic rec_t observe();
        rec_t r;
        r.cle  = bus.nf_cle_o;
        r.ale  = bus.nf_ale_o;
        r.web  = bus.nf_web_o;
        r.dq   = bus.nf_dq_o;
        r.oe   = bus.nf_dq_oe;
        r.clr  = bus.addr_clear;
        r.done = bus.cmd_done;
        r.busy = bus.cmd_busy;
        r.err  = bus.cmd_err;
        return r;
    endfunction

    task automatic push_slot(input logic [7:0] b, input logic is_cmd, input int p, input int h);
        rec_t r;
        for (int k = 0; k < p; k++) begin
            r      = '0;
            r.cle  = is_cmd;
            r.ale  = !is_cmd;
            r.dq   = b;
            r.oe   = 1'b1;
            r.busy = 1'b1;
            r.web  = (k >= p - h);
            exp_q.push_back(r);
        end
    endtask

    // Drives a start pulse at the current negedge and queues the expected trace for clocks 1..end.
    task automatic start_cmd(input logic [7:0] cmd, input logic en, input int cc, input int rc,
                             input logic [31:0] col, input logic [31:0] row,
                             input int tot, input int hi);
        int   p, h, c, r;
        rec_t g;
        bus.nf_cmd             = cmd;
        bus.nf_addr_en         = en;
        bus.nf_column_addr_cnt = 3'(cc);
        bus.nf_row_addr_cnt    = 3'(rc);
        bus.nf_column_addr     = col;
        bus.nf_row_addr        = row;
        bus.nf_total_cycle     = 3'(tot);
        bus.nf_high_cycle      = 4'(hi);
        bus.nf_cmd_valid       = 1'b1;
        p = tot + 2;
        h = (hi < 1) ? 1 : ((hi > p - 1) ? p - 1 : hi);
        c = (cc > ABM) ? ABM : cc;
        r = (rc > ABM) ? ABM : rc;
        push_slot(cmd, 1'b1, p, h);
        if (en) begin
            for (int i = 0; i < c; i++) push_slot(col[8*i +: 8], 1'b0, p, h);
            for (int i = 0; i < r; i++) push_slot(row[8*i +: 8], 1'b0, p, h);
        end
        for (int i = 0; i < GC; i++) begin
            g      = idle_rec();
            g.busy = 1'b1;
            g.done = (i == 0);
            g.clr  = (i == 0) && en;
            exp_q.push_back(g);
        end
        exp_q.push_back(idle_rec());
        @(posedge clk);
        @(negedge clk);
        bus.nf_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rec_t o;
        bus.nf_cmd_valid = 1'b0;
        bus.nf_cmd = 8'h00; bus.nf_addr_en = 1'b0;
        bus.nf_column_addr_cnt = 3'd0; bus.nf_row_addr_cnt = 3'd0;
        bus.nf_column_addr = 32'h0; bus.nf_row_addr = 32'h0;
        bus.nf_total_cycle = 3'd0; bus.nf_high_cycle = 4'd0;
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        o = observe();
        total++;
        if (o !== idle_rec()) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", o, idle_rec());
        end
        rstb = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            o = observe();
            total++;
            if (o !== idle_rec()) begin
                bad++;
                $display("FAIL reset_idle clk=%0d got=%h want=%h", k, o, idle_rec());
            end
        end
    endtask

    task automatic test_full_seq();
        rec_t e, o;
        int   k = 0, done_clk = -1, off_clk = -1;
        start_cmd(8'h00, 1'b1, 2, 3, 32'h0000_0834, 32'h0001_2345, 1, 1);
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
            e = exp_q.pop_front();
            o = observe();
            if (o.done && done_clk < 0) done_clk = k;
            if (!o.busy && off_clk < 0) off_clk = k;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL full_seq clk=%0d got=%h want=%h", k, o, e);
            end
        end
        total++;
        if (done_clk !== 19) begin
            bad++;
            $display("FAIL full_done_clk got=%0d want=19", done_clk);
        end
        total++;
        if (off_clk !== 20) begin
            bad++;
            $display("FAIL full_busy_off got=%0d want=20", off_clk);
        end
    endtask

    task automatic test_cmd_only();
        rec_t e, o;
        int   k = 0, done_clk = -1, clr_seen = 0;
        start_cmd(8'hFF, 1'b0, 0, 0, 32'h0, 32'h0, 0, 0);
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
            e = exp_q.pop_front();
            o = observe();
            if (o.done && done_clk < 0) done_clk = k;
            if (o.clr) clr_seen++;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL cmd_only clk=%0d got=%h want=%h", k, o, e);
            end
        end
        total++;
        if (done_clk !== 3 || clr_seen !== 0) begin
            bad++;
            $display("FAIL cmd_only_done got=%0d/%0d want=3/0", done_clk, clr_seen);
        end
    endtask

    task automatic test_clamp();
        rec_t e, o;
        int   k = 0, ale_clks = 0, clr_seen = 0;
        start_cmd(8'h80, 1'b1, 7, 0, 32'hDDCC_BBAA, 32'h0, 0, 9);
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
            e = exp_q.pop_front();
            o = observe();
            if (o.ale) ale_clks++;
            if (o.clr) clr_seen++;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL clamp clk=%0d got=%h want=%h", k, o, e);
            end
        end
        total++;
        if (ale_clks !== 8 || clr_seen !== 1) begin
            bad++;
            $display("FAIL clamp_count ale_clks/clr got=%0d/%0d want=8/1", ale_clks, clr_seen);
        end
        k = 0; clr_seen = 0;
        start_cmd(8'h60, 1'b1, 0, 0, 32'h1111_1111, 32'h2222_2222, 2, 1);
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
            e = exp_q.pop_front();
            o = observe();
            if (o.clr) clr_seen++;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL zero_addr clk=%0d got=%h want=%h", k, o, e);
            end
        end
        total++;
        if (k !== 6 || clr_seen !== 1) begin
            bad++;
            $display("FAIL zero_addr_len clks/clr got=%0d/%0d want=6/1", k, clr_seen);
        end
    endtask

    task automatic test_overrun();
        rec_t e, o;
        int   k = 0, dones = 0;
        start_cmd(8'h00, 1'b1, 2, 3, 32'h0000_0834, 32'h0001_2345, 1, 1);
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
            e     = exp_q.pop_front();
            e.err = (k == 5);
            o     = observe();
            if (o.done) dones++;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL overrun clk=%0d got=%h want=%h", k, o, e);
            end
            if (k == 4) begin
                bus.nf_cmd_valid = 1'b1;
                bus.nf_cmd       = 8'hAA;
            end
            if (k == 5) bus.nf_cmd_valid = 1'b0;
            if (k == 8) bus.nf_row_addr = 32'hFFFF_FFFF;
        end
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL overrun_done_count got=%0d want=1", dones);
        end
    endtask

    task automatic test_reset_mid();
        rec_t e, o;
        int   k = 0;
        start_cmd(8'h00, 1'b1, 2, 3, 32'h0000_0834, 32'h0001_2345, 1, 1);
        while (k < 7) begin
            @(negedge clk);
            k++;
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid_pre clk=%0d got=%h want=%h", k, o, e);
            end
        end
        rstb = 1'b0;
        exp_q.delete();
        #1;
        o = observe();
        total++;
        if (o !== idle_rec()) begin
            bad++;
            $display("FAIL reset_mid_async got=%h want=%h", o, idle_rec());
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = observe();
            total++;
            if (o !== idle_rec()) begin
                bad++;
                $display("FAIL reset_mid_hold cyc=%0d got=%h want=%h", i, o, idle_rec());
            end
        end
        rstb = 1'b1;
        @(negedge clk);
        k = 0;
        start_cmd(8'h90, 1'b1, 1, 1, 32'h0000_00C3, 32'h0000_005E, 3, 2);
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid_after clk=%0d got=%h want=%h", k, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        int   k = 0;
        start_cmd(8'h5A, 1'b1, 1, 0, 32'h0000_0077, 32'h0, 0, 1);
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
            e     = exp_q.pop_front();
            e.err = (k == 6);
            o     = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b_first clk=%0d got=%h want=%h", k, o, e);
            end
            if (k == 5) begin
                bus.nf_cmd_valid = 1'b1;
                bus.nf_cmd       = 8'h11;
            end
            if (k == 6) bus.nf_cmd_valid = 1'b0;
        end
        k = 0;
        start_cmd(8'h70, 1'b0, 0, 0, 32'h0, 32'h0, 2, 3);
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clk);
            k++;
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b_second clk=%0d got=%h want=%h", k, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_seq();
        test_cmd_only();
        test_clamp();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
